fwd_scoreboard: RTL and testbench

Parametrised forwarding and stall unit for the pipelined CPU. It replaces the per-stage 2:1 forwarding muxes with one scoreboard that does three things:
- tracks in-flight register writes across `DEPTH` downstream stages, each with a Tnew countdown;
- selects, for each of `NREAD` read ports, the newest ready producer value;
- raises a stall when a needed value will not be ready by the consumer's Tuse.

It sits beside the D stage and drives the operand muxes and the D/E pipeline-register controls.

---
 rtl/fwd_scoreboard.sv | 169 ++++++++++++++++
 tb/tb_fwd_scoreboard.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard
//
// Forwarding and stall unit that sits beside the D stage. It keeps a small
// scoreboard of in-flight register writes (one slot per downstream stage,
// slot 0 = E, 1 = M, 2 = W). Each slot remembers whether it writes a
// register, which register, and how many cycles remain until the value is
// ready (tnew). For every read port the newest matching producer is found.
// From that match the unit either forwards the stage value, leaves the
// register-file value in place, or requests a stall.
//
// Optional feature macro: FWD_PERF_CNT_EN
//   When defined, the saturating performance counters stall_cnt and fwd_cnt
//   are added as outputs. When undefined, those ports and registers do not
//   exist.
//
// Parameters:
//   WIDTH  data width
//   AW     register-address width
//   NREAD  number of read ports
//   DEPTH  number of tracked producer stages
//   TW     Tnew/Tuse field width
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset, clears every slot
//   flush        synchronous, invalidates every slot at the next edge
//   issue_valid  D-stage instruction writes a register
//   issue_addr   its destination register
//   issue_tnew   cycles from entering E until its result is ready
//   stage_data   value held in stage k at [k*WIDTH +: WIDTH]
//   rd_addr      source register per read port
//   rd_tuse      cycles until each port needs its value
//   rd_orig      register-file read value per port
//   rd_data      forwarded or original value per port
//   stall        freeze PC and F/D, insert a bubble into E
//   stall_cnt    (FWD_PERF_CNT_EN only) cycles with stall asserted
//   fwd_cnt      (FWD_PERF_CNT_EN only) cycles with at least one forward

module fwd_scoreboard #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int NREAD = 2,
    parameter int DEPTH = 3,
    parameter int TW    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   issue_valid,
    input  logic [AW-1:0]          issue_addr,
    input  logic [TW-1:0]          issue_tnew,
    input  logic [DEPTH*WIDTH-1:0] stage_data,
    input  logic [NREAD*AW-1:0]    rd_addr,
    input  logic [NREAD*TW-1:0]    rd_tuse,
    input  logic [NREAD*WIDTH-1:0] rd_orig,
    output logic [NREAD*WIDTH-1:0] rd_data,
    output logic                   stall
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [15:0]            stall_cnt,
    output logic [15:0]            fwd_cnt
`endif
);

    // Scoreboard slots, index 0 is the youngest (E stage).
    logic [DEPTH-1:0] slot_valid;
    logic [AW-1:0]    slot_addr [DEPTH];
    logic [TW-1:0]    slot_tnew [DEPTH];

    // Per-port match information.
    logic [NREAD-1:0] port_hit;
    logic [TW-1:0]    hit_tnew [NREAD];
    logic [WIDTH-1:0] hit_data [NREAD];

    // Per-port decisions.
    logic [NREAD-1:0] port_stall;
    logic [NREAD-1:0] port_fwd;

    // Whether the D-stage instruction is entered into slot 0 this cycle.
    // Register 0 is never tracked, and a stalled instruction becomes a bubble.
    logic issue_track;

    // Find the newest matching producer for each port. The slots are walked
    // from oldest to youngest so that a younger match overwrites an older
    // one. Older matches are therefore shadowed even when they are ready.
    always_comb begin
        port_hit = '0;
        for (int p = 0; p < NREAD; p++) begin
            hit_tnew[p] = '0;
            hit_data[p] = '0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (slot_valid[k] &&
                    (slot_addr[k] == rd_addr[p*AW +: AW]) &&
                    (slot_addr[k] != '0)) begin
                    port_hit[p] = 1'b1;
                    hit_tnew[p] = slot_tnew[k];
                    hit_data[p] = stage_data[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Turn each match into an action. A ready producer is forwarded. A
    // producer that will not be ready by the consumer's Tuse stalls. A
    // producer that will be ready in time keeps rd_orig, because a later
    // stage forward delivers the real value.
    always_comb begin
        rd_data    = rd_orig;
        port_stall = '0;
        port_fwd   = '0;
        for (int p = 0; p < NREAD; p++) begin
            if (port_hit[p]) begin
                if (hit_tnew[p] == '0) begin
                    rd_data[p*WIDTH +: WIDTH] = hit_data[p];
                    port_fwd[p]               = 1'b1;
                end else if (hit_tnew[p] > rd_tuse[p*TW +: TW]) begin
                    port_stall[p] = 1'b1;
                end
            end
        end
    end

    assign stall       = |port_stall;
    assign issue_track = issue_valid & ~stall & (issue_addr != '0);

    // Advance the scoreboard one stage per cycle. tnew counts down as the
    // producer moves and stays at zero once the value is ready. Flush wins
    // over everything else and leaves every slot empty, including slot 0.
    // Only the valid bits need flushing. Address and tnew of an invalid slot
    // are never looked at.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                slot_addr[k] <= '0;
                slot_tnew[k] <= '0;
            end
        end else begin
            slot_valid[0] <= issue_track & ~flush;
            slot_addr[0]  <= issue_addr;
            slot_tnew[0]  <= issue_tnew;
            for (int k = 1; k < DEPTH; k++) begin
                slot_valid[k] <= slot_valid[k-1] & ~flush;
                slot_addr[k]  <= slot_addr[k-1];
                slot_tnew[k]  <= (slot_tnew[k-1] == '0) ? '0
                                                        : slot_tnew[k-1] - TW'(1);
            end
        end
    end

`ifdef FWD_PERF_CNT_EN
    // Saturating performance counters. Only reset clears them. A flush is
    // normal pipeline activity and must not hide the stalls that caused it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if ((|port_fwd) && (fwd_cnt != 16'hFFFF)) begin
                fwd_cnt <= fwd_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard
//
// Self-checking bench for fwd_scoreboard. A behavioural model keeps a queue
// of recently issued instructions, youngest first. Each entry's remaining
// latency is computed from its age in that queue. A compare process checks
// the DUT against the model on every falling edge. Directed scenarios with
// hand-computed values run first, followed by a randomized phase.

module tb_fwd_scoreboard;

    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int NREAD = 2;
    localparam int DEPTH = 3;
    localparam int TW    = 2;

    logic                   clk;
    logic                   reset;
    logic                   flush;
    logic                   issueValid;
    logic [AW-1:0]          issueAddr;
    logic [TW-1:0]          issueTnew;
    logic [DEPTH*WIDTH-1:0] stageData;
    logic [NREAD*AW-1:0]    rdAddr;
    logic [NREAD*TW-1:0]    rdTuse;
    logic [NREAD*WIDTH-1:0] rdOrig;
    logic [NREAD*WIDTH-1:0] rdData;
    logic                   stall;
`ifdef FWD_PERF_CNT_EN
    logic [15:0]            stallCnt;
    logic [15:0]            fwdCnt;
`endif

    int checks   = 0;
    int failures = 0;
    bit checkEn  = 0;

    typedef struct {
        bit v;
        int addr;
        int tnew;
    } entT;

    // Issued instructions, index 0 = youngest (currently in E).
    entT hist[$];
    int  modelStallCnt;
    int  modelFwdCnt;

    fwd_scoreboard #(
        .WIDTH(WIDTH), .AW(AW), .NREAD(NREAD), .DEPTH(DEPTH), .TW(TW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .issue_valid(issueValid),
        .issue_addr (issueAddr),
        .issue_tnew (issueTnew),
        .stage_data (stageData),
        .rd_addr    (rdAddr),
        .rd_tuse    (rdTuse),
        .rd_orig    (rdOrig),
        .rd_data    (rdData),
        .stall      (stall)
`ifdef FWD_PERF_CNT_EN
        ,
        .stall_cnt  (stallCnt),
        .fwd_cnt    (fwdCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Empty pipeline: DEPTH invalid entries and cleared counters.
    task automatic modelClear();
        entT e;
        e.v = 1'b0;
        e.addr = 0;
        e.tnew = 0;
        hist.delete();
        for (int i = 0; i < DEPTH; i++) hist.push_back(e);
        modelStallCnt = 0;
        modelFwdCnt   = 0;
    endtask

    // Expected outcome for one port. The remaining latency of an entry is
    // its issued tnew minus the number of stages it has already moved.
    function automatic void modelLookup(input int p, output logic [WIDTH-1:0] d,
                                        output bit st, output bit fw);
        int  a;
        int  tu;
        int  rem;
        bit  done;
        a    = int'(rdAddr[p*AW +: AW]);
        tu   = int'(rdTuse[p*TW +: TW]);
        d    = rdOrig[p*WIDTH +: WIDTH];
        st   = 1'b0;
        fw   = 1'b0;
        done = 1'b0;
        for (int i = 0; i < hist.size(); i++) begin
            if (!done && hist[i].v && hist[i].addr == a && a != 0) begin
                done = 1'b1;
                rem  = hist[i].tnew - i;
                if (rem < 0) rem = 0;
                if (rem == 0) begin
                    d  = stageData[i*WIDTH +: WIDTH];
                    fw = 1'b1;
                end else if (rem > tu) begin
                    st = 1'b1;
                end
            end
        end
    endfunction

    function automatic void modelTotals(output bit st, output bit fw);
        logic [WIDTH-1:0] d;
        bit s;
        bit f;
        st = 1'b0;
        fw = 1'b0;
        for (int p = 0; p < NREAD; p++) begin
            modelLookup(p, d, s, f);
            st |= s;
            fw |= f;
        end
    endfunction

    // Clock-edge update of the model, using the inputs of the ending cycle.
    task automatic modelAdvance();
        bit  st;
        bit  fw;
        entT e;
        if (reset) begin
            modelClear();
            return;
        end
        modelTotals(st, fw);
        if (st && modelStallCnt < 65535) modelStallCnt++;
        if (fw && modelFwdCnt < 65535) modelFwdCnt++;
        e.v    = issueValid && !st && (issueAddr != 0);
        e.addr = int'(issueAddr);
        e.tnew = int'(issueTnew);
        hist.push_front(e);
        while (hist.size() > DEPTH) void'(hist.pop_back());
        if (flush) begin
            for (int i = 0; i < hist.size(); i++) hist[i].v = 1'b0;
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        modelAdvance();
        #1;
    endtask

    // Compare every DUT output against the model.
    task automatic checkOutput();
        logic [WIDTH-1:0] d;
        bit st;
        bit fw;
        bit stAll;
        stAll = 1'b0;
        for (int p = 0; p < NREAD; p++) begin
            modelLookup(p, d, st, fw);
            stAll |= st;
            checks++;
            if (rdData[p*WIDTH +: WIDTH] !== d) begin
                failures++;
                $display("[TB] FAIL rd_data[%0d] t=%0t got=%h expected=%h",
                         p, $time, rdData[p*WIDTH +: WIDTH], d);
            end
        end
        checks++;
        if (stall !== stAll) begin
            failures++;
            $display("[TB] FAIL stall t=%0t got=%b expected=%b", $time, stall, stAll);
        end
`ifdef FWD_PERF_CNT_EN
        checks++;
        if (stallCnt !== 16'(modelStallCnt)) begin
            failures++;
            $display("[TB] FAIL stall_cnt t=%0t got=%0d expected=%0d",
                     $time, stallCnt, modelStallCnt);
        end
        checks++;
        if (fwdCnt !== 16'(modelFwdCnt)) begin
            failures++;
            $display("[TB] FAIL fwd_cnt t=%0t got=%0d expected=%0d",
                     $time, fwdCnt, modelFwdCnt);
        end
`endif
    endtask

    always @(negedge clk) begin
        if (checkEn) checkOutput();
    end

    // Hand-computed expectation against the DUT.
    task automatic expectLit(input string name, input logic [WIDTH-1:0] got,
                             input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    // Hand-computed expectation against the model for port 0.
    task automatic pinModel(input string name, input logic [WIDTH-1:0] expData,
                            input bit expStall);
        logic [WIDTH-1:0] d;
        bit st;
        bit fw;
        bit stAll;
        modelLookup(0, d, st, fw);
        modelTotals(stAll, fw);
        checks++;
        if (d !== expData || stAll !== expStall) begin
            failures++;
            $display("[TB] FAIL model_%s got=%h/%b expected=%h/%b",
                     name, d, stAll, expData, expStall);
        end
    endtask

    task automatic applyStimulus();
        reset = ($urandom_range(0, 99) == 0);
        if (reset) modelClear();
        flush      = ($urandom_range(0, 15) == 0);
        issueValid = 1'($urandom_range(0, 1));
        issueAddr  = AW'($urandom_range(0, 3));
        issueTnew  = TW'($urandom_range(0, 3));
        for (int p = 0; p < NREAD; p++) begin
            rdAddr[p*AW +: AW]       = AW'($urandom_range(0, 3));
            rdTuse[p*TW +: TW]       = TW'($urandom_range(0, 3));
            rdOrig[p*WIDTH +: WIDTH] = $urandom;
        end
        for (int k = 0; k < DEPTH; k++) stageData[k*WIDTH +: WIDTH] = $urandom;
    endtask

    // Directed scenarios first, then random traffic.
    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        issueValid = 1'b0;
        issueAddr  = '0;
        issueTnew  = '0;
        stageData  = '0;
        rdAddr     = '0;
        rdTuse     = '0;
        rdOrig     = '0;
        rdOrig[31:0] = 32'h1234;
        modelClear();
        checkEn = 1'b1;

        // Reset holds the scoreboard empty.
        #4;
        expectLit("reset_stall", {31'b0, stall}, 32'h0);
        expectLit("reset_data", rdData[31:0], 32'h1234);
        nextCycle();
        reset = 1'b0;
        #3;
        expectLit("release_stall", {31'b0, stall}, 32'h0);
        expectLit("release_data", rdData[31:0], 32'h1234);

        // E-to-D forward.
        nextCycle();
        issueValid = 1'b1; issueAddr = 5'd8; issueTnew = 2'd0;
        nextCycle();
        issueValid = 1'b0;
        rdAddr[4:0] = 5'd8; rdTuse[1:0] = 2'd1;
        stageData[31:0] = 32'hABCD;
        #3;
        expectLit("e_fwd_data", rdData[31:0], 32'hABCD);
        expectLit("e_fwd_stall", {31'b0, stall}, 32'h0);
        pinModel("e_fwd", 32'hABCD, 1'b0);

        // Load-use: tnew 2 read with tuse 0 stalls exactly two cycles.
        nextCycle();
        rdAddr = '0;
        issueValid = 1'b1; issueAddr = 5'd9; issueTnew = 2'd2;
        nextCycle();
        issueValid = 1'b0;
        rdAddr[4:0] = 5'd9; rdTuse[1:0] = 2'd0;
        stageData[95:64] = 32'h5555_0009;
        #3;
        expectLit("lu_stall1", {31'b0, stall}, 32'h1);
        pinModel("lu_stall1", rdOrig[31:0], 1'b1);
        nextCycle();
        #3;
        expectLit("lu_stall2", {31'b0, stall}, 32'h1);
        nextCycle();
        #3;
        expectLit("lu_release", {31'b0, stall}, 32'h0);
        expectLit("lu_fwd_w", rdData[31:0], 32'h5555_0009);

        // Newest producer shadows the older one.
        nextCycle();
        rdAddr = '0;
        issueValid = 1'b1; issueAddr = 5'd3; issueTnew = 2'd0;
        nextCycle();
        nextCycle();
        issueValid = 1'b0;
        rdAddr[4:0] = 5'd3; rdTuse[1:0] = 2'd0;
        stageData[31:0] = 32'd1; stageData[63:32] = 32'd2;
        #3;
        expectLit("newest_wins", rdData[31:0], 32'd1);
        pinModel("newest", 32'd1, 1'b0);

        // Register zero is never tracked.
        nextCycle();
        rdAddr = '0;
        issueValid = 1'b1; issueAddr = 5'd0; issueTnew = 2'd2;
        nextCycle();
        issueValid = 1'b0;
        rdAddr[4:0] = 5'd0; rdTuse[1:0] = 2'd0; rdOrig[31:0] = 32'hBEEF;
        #3;
        expectLit("r0_stall", {31'b0, stall}, 32'h0);
        expectLit("r0_data", rdData[31:0], 32'hBEEF);

        // Flush in the same cycle as a stall empties the scoreboard.
        nextCycle();
        rdAddr = '0;
        issueValid = 1'b1; issueAddr = 5'd5; issueTnew = 2'd2;
        nextCycle();
        rdAddr[4:0] = 5'd5; rdTuse[1:0] = 2'd0;
        flush = 1'b1;
        #3;
        expectLit("pre_flush_stall", {31'b0, stall}, 32'h1);
        nextCycle();
        flush = 1'b0;
        issueValid = 1'b0;
        #3;
        expectLit("post_flush_stall", {31'b0, stall}, 32'h0);
`ifdef FWD_PERF_CNT_EN
        expectLit("flush_keeps_stall_cnt", {16'b0, stallCnt}, 32'd3);
        expectLit("fwd_cnt_directed", {16'b0, fwdCnt}, 32'd3);
`endif

        // Random traffic over a small register range to provoke hazards.
        for (int c = 0; c < 600; c++) begin
            nextCycle();
            applyStimulus();
        end
        nextCycle();
        reset = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        #1;
        checkEn = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
